// File: rtl/ring_pkg.sv
// Shared types and helpers for the systolic ring processing elements.
package ring_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_N  = 4;

  // Width of the internal arithmetic used for overflow detection; AW must stay below this.
  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  typedef logic [MAX_W-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t sum;
  } sat_res_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Adds two operands already extended to MAX_W bits and checks the exact sum
  // against the aw-bit range. With sat set the result is clamped and ovf flags
  // it; otherwise the raw sum is returned and the caller truncates (wraps).
  function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int aw,
                                       input bit is_signed, input bit sat);
    sat_res_t res;
    wide_t    sum;
    wide_t    max_v;
    wide_t    min_v;
    sum     = a + b;
    res.ovf = 1'b0;
    res.sum = sum;
    if (is_signed) begin
      max_v = (wide_t'(1) << (aw - 1)) - wide_t'(1);
      min_v = ~max_v;
      if ($signed(sum) > $signed(max_v)) begin
        res.ovf = 1'b1;
        res.sum = max_v;
      end else if ($signed(sum) < $signed(min_v)) begin
        res.ovf = 1'b1;
        res.sum = min_v;
      end
    end else begin
      max_v = (wide_t'(1) << aw) - wide_t'(1);
      if (sum > max_v) begin
        res.ovf = 1'b1;
        res.sum = max_v;
      end
    end
    if (!sat) begin
      res.ovf = 1'b0;
      res.sum = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/ring_mac.sv
// Registered multiply-accumulate with synchronous clear, enable and optional
// sticky saturation. sum_next is the accumulator value after the current beat.
module ring_mac
  import ring_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 19,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] x,
  output logic [AW-1:0] sum_next
);

  logic [AW-1:0]   acc;
  logic            sat_hold;
  logic [2*DW-1:0] prod;
  wide_t           prod_w;
  wide_t           acc_w;
  sat_res_t        add_res;

  // Form the full-precision product, extend both operands and add with range check.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    prod   = '0;
    prod_w = '0;
    acc_w  = '0;
    if (SIGNED != 0) begin
      prod   = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{x[DW-1]}}, x});
      prod_w = {{(MAX_W-2*DW){prod[2*DW-1]}}, prod};
      acc_w  = {{(MAX_W-AW){acc[AW-1]}}, acc};
    end else begin
      prod   = {{DW{1'b0}}, a} * {{DW{1'b0}}, x};
      prod_w = {{(MAX_W-2*DW){1'b0}}, prod};
      acc_w  = {{(MAX_W-AW){1'b0}}, acc};
    end
    add_res  = sat_add(acc_w, prod_w, AW, SIGNED != 0, SAT != 0);
    // Once saturated the accumulator holds its clamped value until cleared.
    sum_next = sat_hold ? acc : add_res.sum[AW-1:0];
  end

  // Accumulator and sticky-saturation flag.
  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      sat_hold <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      sat_hold <= 1'b0;
    end else if (en) begin
      acc <= sum_next;
      if (add_res.ovf) sat_hold <= 1'b1;
    end
  end

endmodule

// File: rtl/ring_pe_param.sv
// Parametrised systolic-ring PE: holds one x operand, accumulates a*x over N
// accepted beats, forwards x around the ring and pulses y_valid with the result.
module ring_pe_param
  import ring_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int N      = DEF_N,
  parameter int AW     = 2*DW + clog2(N+1),
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] x_init,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] a_in,
  input  logic          in_valid,
  output logic          busy,
  output logic [DW-1:0] x_out,
  output logic          x_out_valid,
  output logic [AW-1:0] y,
  output logic          y_valid
);

  localparam int            CW   = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] x_reg;
  logic [CW-1:0] cnt;
  logic          clr;
  logic          en;
  logic          last_beat;
  logic [AW-1:0] sum_next;

  ring_mac #(
    .DW    (DW),
    .AW    (AW),
    .SIGNED(SIGNED),
    .SAT   (SAT)
  ) u_mac (
    .clk     (clk),
    .rst     (reset),
    .clr     (clr),
    .en      (en),
    .a       (a_in),
    .x       (x_reg),
    .sum_next(sum_next)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and beat decode: start only counts in IDLE, in_valid only in ACC.
  always_comb begin
    state_next = state;
    clr        = 1'b0;
    en         = 1'b0;
    last_beat  = 1'b0;
    busy       = (state == ACC);
    case (state)
      IDLE: begin
        if (start) begin
          clr        = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          en = 1'b1;
          if (cnt == LAST) begin
            last_beat  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand register, beat counter, ring forwarding and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg       <= '0;
      cnt         <= '0;
      x_out       <= '0;
      x_out_valid <= 1'b0;
      y           <= '0;
      y_valid     <= 1'b0;
    end else begin
      x_out_valid <= 1'b0;
      y_valid     <= 1'b0;
      if (clr) begin
        x_reg <= x_init;
        cnt   <= '0;
      end
      if (en) begin
        x_out       <= x_reg;
        x_out_valid <= 1'b1;
        x_reg       <= x_in;
        cnt         <= cnt + 1'b1;
      end
      if (last_beat) begin
        y       <= sum_next;
        y_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ring_pe_param.sv
// Directed bench for ring_pe_param: an unsigned wrapping PE and a signed
// saturating PE (AW=10), with x_out and y checked against expectation queues.
module tb_ring_pe_param;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int AW0 = 2*DW + $clog2(N+1);
  localparam int AW1 = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            start0, start1;
  logic            iv0, iv1;
  logic [DW-1:0]   x_init, x_in, a_in;

  logic            busy0, xov0, yv0;
  logic [DW-1:0]   x_out0;
  logic [AW0-1:0]  y0;
  logic            busy1, xov1, yv1;
  logic [DW-1:0]   x_out1;
  logic [AW1-1:0]  y1;

  int n_cmp = 0;
  int n_bad = 0;
  int xov_cnt0 = 0;
  int yv_cnt0 = 0;

  logic [DW-1:0]  xq0[$];
  logic [DW-1:0]  xq1[$];
  logic [AW0-1:0] yq0[$];
  logic [AW1-1:0] yq1[$];

  ring_pe_param #(.DW(DW), .N(N)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .x_init(x_init), .x_in(x_in),
    .a_in(a_in), .in_valid(iv0), .busy(busy0), .x_out(x_out0),
    .x_out_valid(xov0), .y(y0), .y_valid(yv0)
  );

  ring_pe_param #(.DW(DW), .N(N), .AW(AW1), .SIGNED(1), .SAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x_init(x_init), .x_in(x_in),
    .a_in(a_in), .in_valid(iv1), .busy(busy1), .x_out(x_out1),
    .x_out_valid(xov1), .y(y1), .y_valid(yv1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every x_out / y pulse pops the oldest expected value.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (xov0) begin
        xov_cnt0++;
        if (xq0.size() == 0) check("x_out0_valid_unexpected", xov0, 0);
        else                 check("x_out0", x_out0, xq0.pop_front());
      end
      if (yv0) begin
        yv_cnt0++;
        if (yq0.size() == 0) check("y0_valid_unexpected", yv0, 0);
        else                 check("y0", y0, yq0.pop_front());
      end
      if (xov1) begin
        if (xq1.size() == 0) check("x_out1_valid_unexpected", xov1, 0);
        else                 check("x_out1", x_out1, xq1.pop_front());
      end
      if (yv1) begin
        if (yq1.size() == 0) check("y1_valid_unexpected", yv1, 0);
        else                 check("y1", y1, yq1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pe(input bit which, input logic [DW-1:0] xi);
    if (which) start1 = 1'b1;
    else       start0 = 1'b1;
    x_init = xi;
    step();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic beat(input bit which, input logic [DW-1:0] a, input logic [DW-1:0] x,
                      input bit st);
    if (which) begin
      iv1 = 1'b1; start1 = st;
    end else begin
      iv0 = 1'b1; start0 = st;
    end
    a_in   = a;
    x_in   = x;
    x_init = 8'h7E;
    step();
    iv0 = 1'b0; iv1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic expect_y0(input string tag, input logic [AW0-1:0] v);
    @(negedge clk);
    check({tag, "_yv_pulse"}, yv0, 1);
    check({tag, "_y"}, y0, v);
    @(negedge clk);
    check({tag, "_yv_low"}, yv0, 0);
    check({tag, "_busy_low"}, busy0, 0);
  endtask

  task automatic expect_y1(input string tag, input logic [AW1-1:0] v);
    @(negedge clk);
    check({tag, "_yv_pulse"}, yv1, 1);
    check({tag, "_y"}, y1, v);
    @(negedge clk);
    check({tag, "_yv_low"}, yv1, 0);
  endtask

  initial begin
    int xov_base;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; iv0 = 1'b0; iv1 = 1'b0;
    x_init = '0; x_in = '0; a_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_x_out", x_out0, 0);
    check("rst_xov", xov0, 0);
    check("rst_y", y0, 0);
    check("rst_yv", yv0, 0);
    reset = 1'b0;
    step();

    // 1: all ones, y = 4, four x_out pulses
    xov_base = xov_cnt0;
    start_pe(0, 8'd1);
    check("t1_busy", busy0, 1);
    repeat (4) xq0.push_back(8'd1);
    yq0.push_back(AW0'(4));
    repeat (4) beat(0, 8'd1, 8'd1, 0);
    expect_y0("t1", AW0'(4));
    check("t1_xov_pulses", xov_cnt0 - xov_base, 4);

    // 2: ring shift, y = 2*1 + 3*2 + 4*3 + 5*4 = 40
    start_pe(0, 8'd2);
    xq0.push_back(8'd2); xq0.push_back(8'd3); xq0.push_back(8'd4); xq0.push_back(8'd5);
    yq0.push_back(AW0'(40));
    beat(0, 8'd1, 8'd3, 0);
    beat(0, 8'd2, 8'd4, 0);
    beat(0, 8'd3, 8'd5, 0);
    beat(0, 8'd4, 8'd9, 0);
    expect_y0("t2", AW0'(40));

    // 3: same stimulus with a three-cycle stall between beats 2 and 3
    start_pe(0, 8'd2);
    xq0.push_back(8'd2); xq0.push_back(8'd3); xq0.push_back(8'd4); xq0.push_back(8'd5);
    yq0.push_back(AW0'(40));
    beat(0, 8'd1, 8'd3, 0);
    beat(0, 8'd2, 8'd4, 0);
    repeat (3) begin
      step();
      @(negedge clk);
      check("t3_stall_busy", busy0, 1);
      check("t3_stall_xov", xov0, 0);
      check("t3_stall_y_hold", y0, 40);
    end
    beat(0, 8'd3, 8'd5, 0);
    beat(0, 8'd4, 8'd9, 0);
    expect_y0("t3", AW0'(40));

    // 5: reset after beat 2 aborts the result; beat 2's x_out never appears
    yv_cnt0 = 0;
    start_pe(0, 8'd1);
    xq0.push_back(8'd1);
    beat(0, 8'd1, 8'd1, 0);
    beat(0, 8'd1, 8'd1, 0);
    reset = 1'b1;
    #1;
    check("t5_rst_busy", busy0, 0);
    check("t5_rst_xov", xov0, 0);
    check("t5_rst_x_out", x_out0, 0);
    check("t5_rst_y", y0, 0);
    check("t5_rst_yv", yv0, 0);
    step();
    step();
    reset = 1'b0;
    step();
    check("t5_no_y_valid", yv_cnt0, 0);
    start_pe(0, 8'd1);
    repeat (4) xq0.push_back(8'd1);
    yq0.push_back(AW0'(4));
    repeat (4) beat(0, 8'd1, 8'd1, 0);
    expect_y0("t5_after", AW0'(4));

    // 6: start ignored in ACC and on the last beat; back-to-back start accepted
    start_pe(0, 8'd3);
    xq0.push_back(8'd3); xq0.push_back(8'd1); xq0.push_back(8'd2); xq0.push_back(8'd3);
    yq0.push_back(AW0'(9));
    beat(0, 8'd1, 8'd1, 1);
    beat(0, 8'd1, 8'd2, 1);
    beat(0, 8'd1, 8'd3, 0);
    beat(0, 8'd1, 8'd7, 1);
    start_pe(0, 8'd2);
    check("t6_b2b_busy", busy0, 1);
    repeat (4) xq0.push_back(8'd2);
    yq0.push_back(AW0'(16));
    repeat (4) beat(0, 8'd2, 8'd2, 0);
    expect_y0("t6_second", AW0'(16));

    // 4: signed saturating PE, -128*127 per beat clamps to -512
    start_pe(1, 8'h80);
    check("t4_busy", busy1, 1);
    repeat (4) xq1.push_back(8'h80);
    yq1.push_back(10'h200);
    repeat (4) beat(1, 8'h7F, 8'h80, 0);
    expect_y1("t4", 10'h200);

    // 4b: negative clamp is sticky; later positive products do not pull it back
    start_pe(1, 8'h80);
    xq1.push_back(8'h80); xq1.push_back(8'h01); xq1.push_back(8'h01); xq1.push_back(8'h01);
    yq1.push_back(10'h200);
    beat(1, 8'h7F, 8'h01, 0);
    beat(1, 8'h7F, 8'h01, 0);
    beat(1, 8'h7F, 8'h01, 0);
    beat(1, 8'h7F, 8'h00, 0);
    expect_y1("t4_sticky_neg", 10'h200);

    // 4c: positive overflow clamps to +511 (wrapping would give 3)
    start_pe(1, 8'h80);
    xq1.push_back(8'h80); xq1.push_back(8'h01); xq1.push_back(8'h01); xq1.push_back(8'h01);
    yq1.push_back(10'h1FF);
    beat(1, 8'h80, 8'h01, 0);
    beat(1, 8'h01, 8'h01, 0);
    beat(1, 8'h01, 8'h01, 0);
    beat(1, 8'h01, 8'h00, 0);
    expect_y1("t4_pos_clamp", 10'h1FF);

    repeat (3) step();
    check("xq0_drained", xq0.size(), 0);
    check("yq0_drained", yq0.size(), 0);
    check("xq1_drained", xq1.size(), 0);
    check("yq1_drained", yq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
